// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - instruction-memory write port between loader and memory
`timescale 1ns/1ps
// Purpose: groups the loader's instruction-memory write bus.
// Signals:
//   we_o     one-cycle write strobe
//   addr_o   ADDR_W-bit word-aligned byte address of the write
//   wdata_o  32-bit instruction word
// Modports: master = loader (drives), slave = instruction memory (receives).
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;

  modport master (output we_o, addr_o, wdata_o);
  modport slave  (input  we_o, addr_o, wdata_o);
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 receiver packing bytes into instruction-memory writes
`timescale 1ns/1ps
// Purpose: receives 8N1 bytes on rx_i, packs every 4 bytes MSB-first into a
// 32-bit word and writes it to instruction memory. Loading ends on the
// terminator word 32'h00000FFF or after MAX_WORDS writes.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   prog_en_i    loader enable; low aborts and clears all loader state
//   rx_i         UART serial input, idle high, asynchronous to clk_i
//   ready_o      loader accepting bytes (registered enable and not done)
//   done_o       terminator or MAX_WORDS reached; sticky while enabled
//   frame_err_o  sticky: a stop bit was sampled low
//   imem         write bus (we_o / addr_o / wdata_o), master side
module uart_prog_loader #(
  parameter int                CLKS_PER_BIT = 868,
  parameter int                ADDR_W       = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                MAX_WORDS    = 4096
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               prog_en_i,
  input  logic               rx_i,
  output logic               ready_o,
  output logic               done_o,
  output logic               frame_err_o,
  uart_prog_loader_if.master imem
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [WCNT_W-1:0] WR_LAST   = WCNT_W'(MAX_WORDS - 1);
  localparam logic [31:0]       TERM_WORD = 32'h0000_0FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK   // stop bit was low; wait for the line to return high
  } rx_state_e;

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              en_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              word_full_q, word_full_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              byte_valid;
  logic [ADDR_W:0]   addr_sum;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      en_q        <= 1'b0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      word_full_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      en_q        <= prog_en_i;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      word_full_q <= word_full_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // Extra bit catches the carry so the address saturates instead of wrapping.
  assign addr_sum = {1'b0, addr_q} + (ADDR_W+1)'(4);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    word_full_d = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    wr_cnt_d    = wr_cnt_q;
    byte_valid  = 1'b0;

    // Receiver. Sampling is timed once from the start-bit edge; a stretched
    // start bit only shifts every sample later within its bit.
    unique case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Word assembly; bytes arriving after done are dropped.
    if (byte_valid && !done_q) begin
      unique case (byte_cnt_q)
        2'd0: word_d[31:24] = shift_q;
        2'd1: word_d[23:16] = shift_q;
        2'd2: word_d[15:8]  = shift_q;
        default: word_d[7:0] = shift_q;
      endcase
      byte_cnt_d  = byte_cnt_q + 1'b1;
      word_full_d = (byte_cnt_q == 2'd3);
    end

    // Evaluate the completed word the cycle after its last byte.
    if (word_full_q) begin
      if (word_q == TERM_WORD) begin
        done_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = word_q;
      end
    end

    // Address stays stable through the strobe and advances right after it.
    if (we_q) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (!addr_sum[ADDR_W]) addr_d = addr_sum[ADDR_W-1:0];
      if (wr_cnt_q == WR_LAST) done_d = 1'b1;
    end

    // Disable overrides everything: abort any byte or partial word.
    if (!prog_en_i) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      bit_idx_d   = '0;
      frame_err_d = 1'b0;
      byte_cnt_d  = '0;
      word_d      = '0;
      word_full_d = 1'b0;
      we_d        = 1'b0;
      addr_d      = BASE_ADDR;
      done_d      = 1'b0;
      wr_cnt_d    = '0;
    end
  end

  assign ready_o      = en_q & ~done_q;
  assign done_o       = done_q;
  assign frame_err_o  = frame_err_q;
  assign imem.we_o    = we_q;
  assign imem.addr_o  = addr_q;
  assign imem.wdata_o = wdata_q;

endmodule
